xor_fold_accumulator: RTL and testbench
=======================================

Name: xor_fold_accumulator

Overview:
Sequential stage directly downstream of the 32-bit structural XOR datapath. It accepts a burst of 1..MAX_WORDS 32-bit words over a valid/ready handshake and folds them into a running XOR checksum. The fold is performed by an instance of the team's thirty_two_bit_xor module, with the accumulator register as one operand. The final checksum, its parity bit and the word count are presented on a held output handshake.

Parameters:
WIDTH, 32, data width; must stay 32 to match thirty_two_bit_xor.
MAX_WORDS, 16, maximum burst length accepted.
CNT_W, 5, width of the length and count fields; must satisfy 2^CNT_W > MAX_WORDS.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  begin burst; sampled only in IDLE.
len  input  CNT_W  burst length; sampled with start.
in_valid  input  1  in_data is valid.
in_ready  output  1  stage accepts a word this cycle.
in_data  input  WIDTH  word to fold.
out_valid  output  1  checksum result available.
out_ready  input  1  consumer takes the result.
out_data  output  WIDTH  XOR of all accepted words.
out_parity  output  1  reduction XOR of out_data.
out_count  output  CNT_W  number of words folded.
busy  output  1  high in ACCUM or DONE.
err_len  output  1  one-cycle pulse on an illegal len.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; acc=0, remaining=0, count=0.
  - All outputs read 0: in_ready, out_valid, out_data, out_parity, out_count, busy, err_len.
- States: IDLE, ACCUM, DONE. Two-bit encoding, registered.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 and 1<=len<=MAX_WORDS: acc<=0, count<=0, remaining<=len, next=ACCUM.
  - start=1 and (len==0 or len>MAX_WORDS): err_len=1 for exactly the next cycle; stay IDLE; acc and count are unchanged.
- ACCUM:
  - in_ready=1 combinationally.
  - Transfer occurs when in_valid && in_ready.
  - On transfer: acc <= acc XOR in_data (through thirty_two_bit_xor), count<=count+1, remaining<=remaining-1.
  - On the transfer with remaining==1: next=DONE.
  - in_valid=0 inserts a bubble; all registers hold.
- DONE:
  - out_valid=1, in_ready=0.
  - out_data=acc, out_parity=^acc, out_count=count; all held stable while out_valid && !out_ready.
  - out_valid && out_ready: next=IDLE. out_data and out_count keep their last value until the next start.
- Latency: first out_valid occurs the cycle after the last word is accepted. A len=N burst with no bubbles takes N cycles in ACCUM.
- Throughput: one word per cycle. Back-to-back bursts need one IDLE cycle: start is sampled in the cycle after the DONE handshake.
- start asserted outside IDLE: ignored, no error.
- in_valid outside ACCUM: ignored, nothing accepted.
- Reset asserted mid-burst or in DONE: immediate return to reset values; the partial checksum is discarded.
- count cannot wrap, because MAX_WORDS < 2^CNT_W. remaining never decrements below 1 in ACCUM.
- busy = (state != IDLE).

Test Plan:
1. Reset, then start with len=1 and in_data=0xDEADBEEF, with out_ready=1 -> out_valid for 1 cycle; out_data=0xDEADBEEF, out_parity=0, out_count=1; state returns to IDLE.
2. len=3 with words 0x0000FFFF, 0xFFFF0000, 0x12345678 and no bubbles -> out_data=0xEDCBA987, out_count=3; out_valid rises exactly 1 cycle after the third transfer.
3. len=2 with bubbles (in_valid toggling 1,0,0,1) and words 0xA5A5A5A5, 0xA5A5A5A4 -> out_data=0x00000001, out_parity=1; no extra word is accepted.
4. Back-pressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_data and out_count stay constant; in_ready=0; start and in_valid are ignored. out_ready=1 -> IDLE.
5. start with len=0, then with len=17 -> err_len pulses 1 cycle each time; busy stays 0; in_ready stays 0.
6. rst_n driven low after 2 of 4 words have been accepted -> all outputs are 0 in the same cycle. A new burst with len=1 and 0x1 then gives out_data=0x00000001 with no leftover state from the aborted burst.

Source files
------------

// File: rtl/xor_fold_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : thirty_two_bit_xor
//  Purpose  : Bitwise 32-bit XOR, built one gate per bit.
//  Ports    : a, b  - 32-bit operands
//             y     - a ^ b
//  Revision : 1.0 - initial release
// ============================================================================
module thirty_two_bit_xor (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  genvar i;
  generate
    for (i = 0; i < 32; i++) begin : g_bit
      assign y[i] = a[i] ^ b[i];
    end
  endgenerate

endmodule

// ============================================================================
//  Module   : xor_fold_accumulator
//  Purpose  : Folds a burst of 1..MAX_WORDS words into a running XOR checksum
//             and presents checksum, parity and word count on a held output
//             handshake.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             start, len            - burst request and length (IDLE only)
//             in_valid/in_ready/in_data    - input word handshake
//             out_valid/out_ready          - result handshake
//             out_data, out_parity, out_count - checksum, ^checksum, count
//             busy                  - burst in progress (ACCUM or DONE)
//             err_len               - one-cycle pulse on an illegal len
//  Revision : 1.0 - initial release
// ============================================================================
module xor_fold_accumulator #(
  parameter int WIDTH     = 32,
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             busy,
  output logic             err_len
);

  localparam logic [CNT_W-1:0] c_max_len = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_remaining;
  logic             r_err;
  logic [WIDTH-1:0] w_fold;
  logic             w_len_ok;
  logic             w_xfer;

  assign w_len_ok = (len != '0) && (len <= c_max_len);
  assign w_xfer   = in_valid && in_ready;

  // The fold operand is the accumulator itself; r_acc is only written on a
  // transfer, so the XOR output is don't-care in every other cycle.
  thirty_two_bit_xor u_xor (
    .a (r_acc),
    .b (in_data),
    .y (w_fold)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start && w_len_ok) begin
          w_next = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (w_xfer && (r_remaining == c_one)) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
        busy   = 1'b0;
      end
    endcase
  end

  // Datapath: accumulator, counters and the registered length-error pulse.
  // acc/count are cleared only on a legal start so the last result stays
  // visible on out_data/out_count after the DONE handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_remaining <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_len_ok) begin
              r_acc       <= '0;
              r_count     <= '0;
              r_remaining <= len;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_ACCUM: begin
          if (w_xfer) begin
            r_acc       <= w_fold;
            r_count     <= r_count + c_one;
            r_remaining <= r_remaining - c_one;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data   = r_acc;
  assign out_parity = ^r_acc;
  assign out_count  = r_count;
  assign err_len    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_xor_fold_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xor_fold_accumulator
//  Purpose  : Directed-vector bench for xor_fold_accumulator. Expected results
//             are hand-computed and queued by the driver; a monitor pops them
//             on every out_valid && out_ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xor_fold_accumulator;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             parity;
    logic [CNT_W-1:0] count;
  } result_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_parity;
  logic [CNT_W-1:0] out_count;
  logic             busy;
  logic             err_len;

  int      checks   = 0;
  int      failures = 0;
  result_t exp_q[$];

  xor_fold_accumulator #(
    .WIDTH     (32),
    .MAX_WORDS (16),
    .CNT_W     (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_parity (out_parity),
    .out_count  (out_count),
    .busy       (busy),
    .err_len    (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares every accepted result against the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got 0x%08h expected none", out_data);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        check("sb_data",   out_data,          e.data);
        check("sb_parity", 32'(out_parity),   32'(e.parity));
        check("sb_count",  32'(out_count),    32'(e.count));
      end
    end
  end

  // All tasks start and end at posedge+1, with inputs taking effect at the
  // following posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [CNT_W-1:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] d, input bit last);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    check("in_ready_accum", 32'(in_ready), 32'd1);
    if (last) check("no_early_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    if (last) check("valid_latency", 32'(out_valid), 32'd1);
  endtask

  task automatic bubble();
    in_valid = 1'b0;
    @(negedge clk);
    check("bubble_ready", 32'(in_ready), 32'd1);
    check("bubble_no_valid", 32'(out_valid), 32'd0);
    step();
  endtask

  task automatic finish_done();
    out_ready = 1'b1;
    step();
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1;
    step();
    // Reset state
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_parity",    32'(out_parity), 32'd0);
    check("rst_count",     32'(out_count), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_err",       32'(err_len),   32'd0);
    rst_n = 1'b1;
    step();

    // 1: single word
    issue_start(5'd1);
    check("t1_busy", 32'(busy), 32'd1);
    exp_q.push_back('{32'hDEADBEEF, 1'b0, 5'd1});
    send_word(32'hDEADBEEF, 1'b1);
    finish_done();
    check("t1_hold_data", out_data, 32'hDEADBEEF);
    step();

    // 2: three words, no bubbles
    issue_start(5'd3);
    exp_q.push_back('{32'hEDCBA987, 1'b1, 5'd3});
    send_word(32'h0000FFFF, 1'b0);
    send_word(32'hFFFF0000, 1'b0);
    send_word(32'h12345678, 1'b1);
    finish_done();
    step();

    // 3: two words with bubbles (valid 1,0,0,1)
    issue_start(5'd2);
    exp_q.push_back('{32'h00000001, 1'b1, 5'd2});
    send_word(32'hA5A5A5A5, 1'b0);
    bubble();
    bubble();
    send_word(32'hA5A5A5A4, 1'b1);
    finish_done();
    step();

    // 4: back-pressure in DONE, start/in_valid ignored
    issue_start(5'd2);
    send_word(32'h11111111, 1'b0);
    out_ready = 1'b0;
    send_word(32'h22222222, 1'b1);
    start = 1'b1; len = 5'd1; in_valid = 1'b1; in_data = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data",  out_data, 32'h33333333);
      check("bp_count", 32'(out_count), 32'd2);
      check("bp_ready", 32'(in_ready), 32'd0);
      step();
    end
    start = 1'b0; in_valid = 1'b0;
    exp_q.push_back('{32'h33333333, 1'b0, 5'd2});
    finish_done();
    step();

    // 5: illegal lengths
    issue_start(5'd0);
    check("len0_err",   32'(err_len),  32'd1);
    check("len0_busy",  32'(busy),     32'd0);
    check("len0_ready", 32'(in_ready), 32'd0);
    step();
    check("len0_pulse_end", 32'(err_len), 32'd0);
    issue_start(5'd17);
    check("len17_err",   32'(err_len),  32'd1);
    check("len17_busy",  32'(busy),     32'd0);
    check("len17_ready", 32'(in_ready), 32'd0);
    check("len17_data_kept", out_data, 32'h33333333);
    step();
    check("len17_pulse_end", 32'(err_len), 32'd0);

    // 6: reset mid-burst
    issue_start(5'd4);
    send_word(32'hAAAA0000, 1'b0);
    send_word(32'h0000BBBB, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_data",  out_data,        32'd0);
    check("abort_count", 32'(out_count),  32'd0);
    check("abort_busy",  32'(busy),       32'd0);
    check("abort_ready", 32'(in_ready),   32'd0);
    check("abort_valid", 32'(out_valid),  32'd0);
    step();
    rst_n = 1'b1;
    step();
    issue_start(5'd1);
    exp_q.push_back('{32'h00000001, 1'b1, 5'd1});
    send_word(32'h00000001, 1'b1);
    finish_done();
    step();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
